// File: rtl/ps2_pkg.sv
// Shared constants and frame-state encoding for the PS/2 key encoder.
package ps2_pkg;

  localparam logic [7:0] PS2_E0      = 8'hE0;
  localparam logic [7:0] PS2_F0      = 8'hF0;
  localparam logic [7:0] PS2_E1      = 8'hE1;
  localparam logic [7:0] PS2_PRT_MK  = 8'h12;
  localparam logic [7:0] PS2_PRT_BRK = 8'h7C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // True for bytes that always announce further bytes of the same key event.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_E0) || (b == PS2_F0) || (b == PS2_E1);
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: synchronizers, clock filter, frame FSM, timeout.
module ps2_rx_byte #(
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_vld,
  output logic       parity_err,
  output logic       frame_abort
);
  import ps2_pkg::*;

  localparam int unsigned FILT_W  = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_MAX = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned TMO_W   = $clog2(TMO_MAX + 1);

  logic              clk_s1, clk_s2, dat_s1, dat_s2;
  logic              clk_filt;
  logic [FILT_W-1:0] filt_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              edge_acc, fall, tmo_hit;

  frame_state_t state, state_d;
  logic [7:0]   shreg, shreg_d;
  logic [2:0]   bit_cnt, bit_cnt_d;
  logic         par_ok, par_ok_d;
  logic         vld_d, err_d, abort_d;

  // Two-stage synchronizers; lines idle high.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // A new clock level is accepted on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    edge_acc = (clk_s2 != clk_filt) && (filt_cnt == FILT_W'(FILTER_LEN - 1));
    fall     = edge_acc && clk_filt;
    tmo_hit  = (state != ST_IDLE) && (tmo_cnt == TMO_W'(TMO_MAX));
  end

  // Clock-level filter.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (edge_acc) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  // Idle timer: reloads on any filtered edge, saturates at the limit.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (edge_acc) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_W'(TMO_MAX)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Frame FSM next state; a filtered edge takes priority over a timeout.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    par_ok_d  = par_ok;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    abort_d   = 1'b0;
    if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!dat_s2) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {dat_s2, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = (^shreg) ^ dat_s2;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dat_s2 && par_ok) vld_d = 1'b1;
          else                  err_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit && !edge_acc) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      par_ok      <= 1'b0;
      data_byte   <= '0;
      byte_vld    <= 1'b0;
      parity_err  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      bit_cnt     <= bit_cnt_d;
      par_ok      <= par_ok_d;
      byte_vld    <= vld_d;
      parity_err  <= err_d;
      frame_abort <= abort_d;
      if (vld_d) data_byte <= shreg;
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// Groups received PS/2 bytes into one 65-bit key event word with a toggle bit.
module ps2_key_encoder #(
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [64:0] ps2_key,
  output logic        parity_err
);
  import ps2_pkg::*;

  logic [7:0]  data_byte;
  logic        byte_vld, frame_abort;
  // Only 7 bytes are ever held before an emit, so the top accumulator byte is never needed.
  logic [55:0] acc;
  logic [3:0]  n, n_inc;
  logic        pause, pause_nx, prtscr, emit;
  logic [63:0] seq;

  ps2_rx_byte #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US),
    .FILTER_LEN(FILTER_LEN)
  ) u_rx (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (data_byte),
    .byte_vld   (byte_vld),
    .parity_err (parity_err),
    .frame_abort(frame_abort)
  );

  // Decide whether the incoming byte completes the event.
  always_comb begin
    seq      = {acc, data_byte};
    n_inc    = n + 4'd1;
    pause_nx = pause || ((n == 4'd0) && (data_byte == PS2_E1));
    prtscr   = ((n_inc == 4'd2) && (seq[15:0] == {PS2_E0, PS2_PRT_MK})) ||
               ((n_inc == 4'd3) && (seq[23:0] == {PS2_E0, PS2_F0, PS2_PRT_BRK}));
    if (pause_nx) emit = (n_inc == 4'd8);
    else          emit = (n_inc == 4'd8) || !(is_prefix(data_byte) || prtscr);
  end

  // Accumulator, byte count and published event word.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      n       <= '0;
      pause   <= 1'b0;
      ps2_key <= '0;
    end else if (parity_err || frame_abort) begin
      acc   <= '0;
      n     <= '0;
      pause <= 1'b0;
    end else if (byte_vld) begin
      if (emit) begin
        ps2_key <= {~ps2_key[64], seq};
        acc     <= '0;
        n       <= '0;
        pause   <= 1'b0;
      end else begin
        acc   <= seq[55:0];
        n     <= n_inc;
        pause <= pause_nx;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder: directed PS/2 frames, queued expected events.
module tb_ps2_key_encoder;
  localparam int unsigned HALF = 20;

  logic        clk_sys = 1'b0;
  logic        reset, ps2_clk, ps2_data;
  logic [64:0] ps2_key;
  logic        parity_err;

  int          errors = 0, checks = 0;
  logic [64:0] exp_q[$];
  logic        exp_tog = 1'b0;
  int          tog_cnt = 0, perr_cnt = 0, exp_perr = 0;
  logic        last_tog = 1'b0, last_perr = 1'b0;

  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder #(
    .CLK_HZ    (1_000_000),
    .TIMEOUT_US(200),
    .FILTER_LEN(8)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .parity_err(parity_err)
  );

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] v);
    exp_tog = ~exp_tog;
    exp_q.push_back({exp_tog, v});
  endtask

  // Sends the first nbits of a frame; glitch adds a short low pulse in each high phase.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] fr;
    logic        p;
    p  = ~(^b) ^ bad_par;
    fr = {1'b1, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch) begin
        repeat (8) @(posedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk_sys);
        ps2_clk = 1'b1;
        repeat (9) @(posedge clk_sys);
      end else begin
        repeat (HALF) @(posedge clk_sys);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk_sys);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(posedge clk_sys);
    ps2_data = 1'b1;
    repeat (3 * HALF) @(posedge clk_sys);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk_sys);
    end
    chk(name, 65'(exp_q.size()), 65'd0);
    exp_q.delete();
  endtask

  // Monitor: pops and compares on every toggle of bit 64, tracks parity_err pulses.
  initial begin : monitor
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        last_tog  = ps2_key[64];
        last_perr = 1'b0;
      end else begin
        if (parity_err) begin
          perr_cnt++;
          chk("perr_width", {64'd0, last_perr}, 65'd0);
        end
        last_perr = parity_err;
        if (ps2_key[64] != last_tog) begin
          tog_cnt++;
          last_tog = ps2_key[64];
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL event_unexpected: got %h expected none", ps2_key);
          end else begin
            chk("event", ps2_key, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("reset_key", ps2_key, 65'd0);
    chk("reset_perr", {64'd0, parity_err}, 65'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk_sys);

    // Make key
    push(64'h1C);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    wait_drain("drain_make");

    // Extended break
    push(64'hE0F075);
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h75, 1'b0, 11, 1'b0);
    wait_drain("drain_ext_break");

    // PrtScr make
    push(64'hE012E07C);
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h12, 1'b0, 11, 1'b0);
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h7C, 1'b0, 11, 1'b0);
    wait_drain("drain_prtscr");

    // Pause
    begin
      logic [63:0] pause_seq;
      pause_seq = 64'hE11477E1F014F077;
      push(pause_seq);
      for (int i = 7; i >= 0; i--) send_frame(pause_seq[i*8 +: 8], 1'b0, 11, 1'b0);
    end
    wait_drain("drain_pause");

    // Bad parity drops the pending prefix
    exp_perr++;
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    push(64'h29);
    send_frame(8'h29, 1'b0, 11, 1'b0);
    wait_drain("drain_badpar");

    // Timeout mid-frame
    send_frame(8'h33, 1'b0, 5, 1'b0);
    repeat (400) @(posedge clk_sys);
    push(64'h5A);
    send_frame(8'h5A, 1'b0, 11, 1'b0);
    wait_drain("drain_timeout");

    // Glitches on ps2_clk inside a frame
    push(64'h2B);
    send_frame(8'h2B, 1'b0, 11, 1'b1);
    wait_drain("drain_glitch");

    // Reset mid-frame after F0
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 4, 1'b0);
    @(posedge clk_sys);
    #1 reset = 1'b1;
    #1;
    chk("reset_mid_key", ps2_key, 65'd0);
    exp_tog = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk_sys);
    push(64'h1C);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    wait_drain("drain_after_reset");

    repeat (50) @(posedge clk_sys);
    chk("toggle_count", 65'(tog_cnt), 65'd8);
    chk("perr_count", 65'(perr_cnt), 65'(exp_perr));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_encoder.md
# ps2_key_encoder

Produces the 65-bit `ps2_key` event word consumed by the core's keyboard decoder from raw PS/2 keyboard clock/data lines. It deserializes 11-bit PS/2 device-to-host frames and groups prefix bytes (E0, F0, E1) with their terminal byte into one event. Each completed event is published with a toggled bit 64. It sits between the board's PS/2 pins and the `emu` keyboard decoder, standing in for the HPS-side key source on builds that read a keyboard directly.

## Interface
- `CLK_HZ`, 24_000_000: `clk_sys` frequency; sets the timeout count.
- `TIMEOUT_US`, 200: maximum idle time inside a frame before it is aborted.
- `FILTER_LEN`, 8: number of consecutive equal samples needed to accept a new `ps2_clk` level.
- `clk_sys`, in, 1: single clock for the whole block.
- `reset`, in, 1: asynchronous, active-high.
- `ps2_clk`, in, 1: raw PS/2 clock, asynchronous.
- `ps2_data`, in, 1: raw PS/2 data, asynchronous.
- `ps2_key`, out, 65: event word. Bits [7:0] hold the terminal byte, [15:8] the previous byte, [23:16] the byte before that, and [63:24] the earlier bytes, with the newest of those in the lowest position. Bit [64] toggles once per event.
- `parity_err`, out, 1: one-cycle pulse when a frame with bad parity or a bad start/stop bit is dropped.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. The `ps2_clk` level is then filtered: a new level is accepted only after `FILTER_LEN` identical samples. A bit is sampled on each filtered falling edge.
- **Frame FSM (`ps2_rx_byte`):**
  - States: IDLE, DATA, PARITY, STOP.
  - IDLE goes to DATA when the start bit = 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA shifts 8 bits, LSB first.
  - PARITY checks odd parity over the 8 data bits plus the parity bit.
  - STOP requires 1. A good frame pulses `byte_vld` with `byte`. A bad frame pulses `parity_err`.
  - After STOP the FSM returns to IDLE in either case.
- **Timeout:** a counter reloads on every filtered clock edge. If it reaches `CLK_HZ/1_000_000*TIMEOUT_US` while the FSM is not in IDLE, the frame is aborted and the FSM returns to IDLE. No pulse is generated.
- **Sequence assembly:**
  - A 64-bit accumulator `acc` and a 4-bit byte count `n` are kept.
  - On `byte_vld`: `acc <= {acc[55:0], byte}` and `n <= n+1`.
  - Terminate (emit) when the byte is not E0/F0/E1 and no continuation rule applies.
  - Continuation rule 1: the sequence so far is E0 12 or E0 F0 7C (PrtScr first halves). Continue instead of emitting.
  - Continuation rule 2: the first byte is E1 (Pause). Collect exactly 8 bytes, then emit.
  - Forced emit: if `n` reaches 8 without a terminal byte, emit anyway.
- **Emit:** `ps2_key[63:0] <= {acc[55:0], byte}` and `ps2_key[64] <= ~ps2_key[64]`. Then `acc <= 0` and `n <= 0`.
- **Bad frame:** a `parity_err` or timeout also clears `acc` and `n`. The partial sequence is discarded and no event is emitted.
- **Reset:** `ps2_key` = 0 (including bit 64), `parity_err` = 0, `acc` = 0, `n` = 0, FSM in IDLE. The filtered clock level resets to 1 (the PS/2 lines idle high).

## Timing
- A filtered falling edge is registered 2 (synchronizer) + `FILTER_LEN` cycles after the raw edge.
- `byte_vld` fires 1 cycle after the stop-bit sample.
- `ps2_key` updates 1 cycle after `byte_vld`. All 65 bits change in that same cycle.
- Minimum spacing between two events is one PS/2 frame (about 0.6 ms at 16.7 kHz). No back-pressure is needed and none exists.
- `parity_err` is exactly 1 cycle wide.
- `ps2_key` holds between events.
- An abort from reset or timeout mid-frame never produces a partial `ps2_key` update.
- A timeout and a filtered edge in the same cycle: the edge wins and the counter reloads.

## Structure
- Package `ps2_pkg` holds:
  - constants `PS2_E0 = 8'hE0`, `PS2_F0 = 8'hF0`, `PS2_E1 = 8'hE1`;
  - the PrtScr middle bytes 12 and 7C;
  - the frame-state enum.
- Sub-module `ps2_rx_byte` contains the synchronizers, filter, frame FSM, parity check and timeout. Its outputs are `byte`, `byte_vld` and `parity_err`.
- The top level contains the accumulator, the continuation rules and the toggle.

## Test plan
- **Make key:** frame 1C -> `ps2_key[63:0]` = 0x1C, bit 64 goes 0→1, `parity_err` stays 0.
- **Extended break:** frames E0, F0, 75 -> one event with `[23:0]` = E0F075 and `[63:24]` = 0. Bit 64 toggles exactly once.
- **PrtScr and Pause:**
  - PrtScr make E0 12 E0 7C -> one event with `[31:0]` = E012E07C.
  - Pause E1 14 77 E1 F0 14 F0 77 -> one event with `[63:0]` = E11477E1F014F077.
- **Bad parity:** send E0, then 1C with bad parity -> `parity_err` pulses once and there is no toggle. Then send 29 -> event `[63:0]` = 0x29 (the dropped E0 is not prepended).
- **Timeout:** stop `ps2_clk` after 5 bits for more than `TIMEOUT_US` -> the FSM returns to IDLE and there is no event. A following full frame 5A -> event 0x5A.
- **Reset and glitches:**
  - Assert `reset` mid-frame after byte F0 -> `ps2_key` = 0 immediately. After release, frame 1C -> event 0x1C with bit 64 = 1.
  - Glitch pulses on `ps2_clk` shorter than `FILTER_LEN` cycles -> no extra bit is sampled.
